hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
Parametrised next-generation hazard controller for the 5-stage MIPS pipeline. It adds four things to plain load-use detection:
- register-use qualification, so unused source fields never stall;
- ID-stage branch operand interlocks;
- a sequential multiply/divide busy tracker with HI/LO read interlock;
- optional non-delay-slot branch squash and a saturating stall performance counter.

It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register controls.

Parameters:
REG_AW, 5, register address width.
MD_LAT, 4, cycles mul/div occupies HI/LO after issue in EX (1..15).
DELAY_SLOT, 1, 1 = MIPS branch delay slot (never squash IF/ID); 0 = squash the fetched instruction on a taken branch.
CNT_W, 16, stall performance counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Rs_ID  in  REG_AW  rs of the instruction in ID
Rt_ID  in  REG_AW  rt of the instruction in ID
RsUsed_ID  in  1  ID instruction reads rs
RtUsed_ID  in  1  ID instruction reads rt
isBranch  in  1  ID instruction is a branch/jr (compares in ID)
BranchTaken_ID  in  1  branch in ID resolves taken
MDOp_ID  in  1  ID instruction is mult/div
MFHiLo_ID  in  1  ID instruction is mfhi/mflo
RegWtaddr_EX  in  REG_AW  destination in EX
RegWrite_EX  in  1  EX instruction writes the register file
DMemRead_EX  in  1  EX instruction is a load
RegWtaddr_MEM  in  REG_AW  destination in MEM
RegWrite_MEM  in  1  MEM instruction writes the register file
DMemRead_MEM  in  1  MEM instruction is a load
MDStart_EX  in  1  mult/div issuing in EX this cycle
PCEn  out  1  PC write enable
IF_ID_En  out  1  IF/ID write enable
ID_EX_Flush  out  1  insert bubble into ID/EX
IF_ID_Flush  out  1  squash IF/ID contents
MDBusy  out  1  HI/LO result pending
StallCnt  out  CNT_W  saturating count of stall cycles

Behaviour:
Match qualifiers:
- mRs(X) = RsUsed_ID && Rs_ID!=0 && Rs_ID==RegWtaddr_X && RegWrite_X.
- mRt(X) is the same using rt.
- m(X) = mRs(X) || mRt(X).

Stall terms, all combinational, same cycle:
- load_use = DMemRead_EX && m(EX).
- br_ex = isBranch && m(EX), covering both ALU and load producers.
- br_mem = isBranch && DMemRead_MEM && m(MEM).
- md_hazard = MDBusy && (MFHiLo_ID || MDOp_ID).
- stall = load_use | br_ex | br_mem | md_hazard.

Pipeline controls:
- PCEn = IF_ID_En = ~stall.
- ID_EX_Flush = stall.
- IF_ID_Flush = (DELAY_SLOT==0) && BranchTaken_ID && isBranch && !stall.
- A stalled branch never squashes.

Mul/div counter (md_cnt, 4 bits):
- Reset to 0.
- MDStart_EX loads MD_LAT. Otherwise, if nonzero, it decrements by 1.
- MDStart_EX while md_cnt!=0 reloads MD_LAT (restart wins over decrement).
- MDBusy = (md_cnt!=0), registered-derived.
- Issue in EX at cycle t: MDBusy is high for cycles t+1 .. t+MD_LAT. A dependent mfhi in ID is released at cycle t+MD_LAT+1.

StallCnt:
- Reset to 0.
- Increments on each clk edge where stall=1 and rst=0.
- Saturates at all-ones with no wrap.

Reset:
- Asynchronous. md_cnt=0, MDBusy=0, StallCnt=0 immediately.
- While rst=1: PCEn=0, IF_ID_En=0, ID_EX_Flush=1, IF_ID_Flush=0, overriding all terms.
- Reset asserted mid-mul/div discards the pending busy state.
- First edge after deassertion operates normally.

Register $0:
- Writes to $0 never cause a stall, even when RegWrite is set.

Test Plan:
- Load-use: DMemRead_EX=1, RegWrite_EX=1, RegWtaddr_EX=8, Rs_ID=8, RsUsed_ID=1 -> stall one cycle (PCEn=0, ID_EX_Flush=1); same with RsUsed_ID=0 -> no stall; RegWtaddr_EX=0, Rs_ID=0 -> no stall.
- Branch interlock: isBranch=1, ALU producer in EX writing rt=9 -> stall; next cycle it is in MEM as non-load -> no stall; if MEM is a load to 9 -> exactly one further stall cycle.
- Mul/div with MD_LAT=4: MDStart_EX pulse at cycle 10, mfhi in ID from cycle 11 -> MDBusy=1 for cycles 11-14, stall for cycles 11-14, PCEn=1 at cycle 15; back-to-back MDStart reloads the count to 4.
- Branch squash: DELAY_SLOT=0, isBranch=1, BranchTaken_ID=1, no hazards -> IF_ID_Flush=1; with a concurrent load-use stall -> IF_ID_Flush=0; DELAY_SLOT=1 -> IF_ID_Flush is always 0.
- Counter: CNT_W=3, hold stall for 10 cycles -> StallCnt reads 7 and stays at 7; assert rst asynchronously mid-cycle -> StallCnt=0 and MDBusy=0 before the next edge, PCEn=0 while reset is held.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use, ID-branch
// and HI/LO interlocks, optional branch squash, saturating stall counter.
module hazard_ctrl_mc #(
    parameter int REG_AW     = 5,
    parameter int MD_LAT     = 4,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic              RsUsed_ID,
    input  logic              RtUsed_ID,
    input  logic              isBranch,
    input  logic              BranchTaken_ID,
    input  logic              MDOp_ID,
    input  logic              MFHiLo_ID,
    input  logic [REG_AW-1:0] RegWtaddr_EX,
    input  logic              RegWrite_EX,
    input  logic              DMemRead_EX,
    input  logic [REG_AW-1:0] RegWtaddr_MEM,
    input  logic              RegWrite_MEM,
    input  logic              DMemRead_MEM,
    input  logic              MDStart_EX,
    output logic              PCEn,
    output logic              IF_ID_En,
    output logic              ID_EX_Flush,
    output logic              IF_ID_Flush,
    output logic              MDBusy,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT);

    logic [3:0] md_cnt;
    logic       rs_nz;
    logic       rt_nz;
    logic       m_ex;
    logic       m_mem;
    logic       load_use;
    logic       br_ex;
    logic       br_mem;
    logic       md_hazard;
    logic       stall;

    assign rs_nz = RsUsed_ID && (Rs_ID != '0);
    assign rt_nz = RtUsed_ID && (Rt_ID != '0);

    assign m_ex = RegWrite_EX &&
                  ((rs_nz && Rs_ID == RegWtaddr_EX) ||
                   (rt_nz && Rt_ID == RegWtaddr_EX));

    assign m_mem = RegWrite_MEM &&
                   ((rs_nz && Rs_ID == RegWtaddr_MEM) ||
                    (rt_nz && Rt_ID == RegWtaddr_MEM));

    assign MDBusy    = (md_cnt != 4'd0);
    assign load_use  = DMemRead_EX && m_ex;
    assign br_ex     = isBranch && m_ex;
    assign br_mem    = isBranch && DMemRead_MEM && m_mem;
    assign md_hazard = MDBusy && (MFHiLo_ID || MDOp_ID);
    assign stall     = load_use | br_ex | br_mem | md_hazard;

    // Reset holds the front end frozen with a bubble going into EX.
    always_comb begin
        PCEn        = 1'b0;
        IF_ID_En    = 1'b0;
        ID_EX_Flush = 1'b1;
        IF_ID_Flush = 1'b0;
        if (!rst) begin
            PCEn        = ~stall;
            IF_ID_En    = ~stall;
            ID_EX_Flush = stall;
            IF_ID_Flush = (DELAY_SLOT == 0) && BranchTaken_ID &&
                          isBranch && !stall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt <= 4'd0;
        end else if (MDStart_EX) begin
            md_cnt <= MD_LOAD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt <= '0;
        end else if (stall && (StallCnt != '1)) begin
            StallCnt <= StallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: a delay-slot instance and a squash instance
// with a 3-bit counter share stimulus; results go through a check queue.
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs_ID, Rt_ID, RegWtaddr_EX, RegWtaddr_MEM;
    logic       RsUsed_ID, RtUsed_ID, isBranch, BranchTaken_ID;
    logic       MDOp_ID, MFHiLo_ID, RegWrite_EX, DMemRead_EX;
    logic       RegWrite_MEM, DMemRead_MEM, MDStart_EX;

    logic        pc_a, ifen_a, exfl_a, iffl_a, busy_a;
    logic [15:0] cnt_a;
    logic        pc_b, ifen_b, exfl_b, iffl_b, busy_b;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_ctrl_mc dut (
        .clk(clk), .rst(rst),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .RsUsed_ID(RsUsed_ID), .RtUsed_ID(RtUsed_ID),
        .isBranch(isBranch), .BranchTaken_ID(BranchTaken_ID),
        .MDOp_ID(MDOp_ID), .MFHiLo_ID(MFHiLo_ID),
        .RegWtaddr_EX(RegWtaddr_EX), .RegWrite_EX(RegWrite_EX),
        .DMemRead_EX(DMemRead_EX),
        .RegWtaddr_MEM(RegWtaddr_MEM), .RegWrite_MEM(RegWrite_MEM),
        .DMemRead_MEM(DMemRead_MEM), .MDStart_EX(MDStart_EX),
        .PCEn(pc_a), .IF_ID_En(ifen_a), .ID_EX_Flush(exfl_a),
        .IF_ID_Flush(iffl_a), .MDBusy(busy_a), .StallCnt(cnt_a)
    );

    hazard_ctrl_mc #(.DELAY_SLOT(0), .CNT_W(3)) dut_sq (
        .clk(clk), .rst(rst),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .RsUsed_ID(RsUsed_ID), .RtUsed_ID(RtUsed_ID),
        .isBranch(isBranch), .BranchTaken_ID(BranchTaken_ID),
        .MDOp_ID(MDOp_ID), .MFHiLo_ID(MFHiLo_ID),
        .RegWtaddr_EX(RegWtaddr_EX), .RegWrite_EX(RegWrite_EX),
        .DMemRead_EX(DMemRead_EX),
        .RegWtaddr_MEM(RegWtaddr_MEM), .RegWrite_MEM(RegWrite_MEM),
        .DMemRead_MEM(DMemRead_MEM), .MDStart_EX(MDStart_EX),
        .PCEn(pc_b), .IF_ID_En(ifen_b), .ID_EX_Flush(exfl_b),
        .IF_ID_Flush(iffl_b), .MDBusy(busy_b), .StallCnt(cnt_b)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic rsu, rtu, br, tk, mdop, mfh, md;
        logic [4:0] wex;
        logic rwex, ldex;
        logic [4:0] wmem;
        logic rwmem, ldmem;
        logic st, sq;
    } vec_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(
        logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
        logic br, logic tk, logic mdop, logic mfh, logic md,
        logic [4:0] wex, logic rwex, logic ldex,
        logic [4:0] wmem, logic rwmem, logic ldmem,
        logic st, logic sq);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu;
        v.br = br; v.tk = tk; v.mdop = mdop; v.mfh = mfh; v.md = md;
        v.wex = wex; v.rwex = rwex; v.ldex = ldex;
        v.wmem = wmem; v.rwmem = rwmem; v.ldmem = ldmem;
        v.st = st; v.sq = sq;
        return v;
    endfunction

    function automatic logic [31:0] act(int sel);
        case (sel)
            0: return {26'd0, exfl_b, ~pc_b, ~ifen_b,
                       exfl_a, ~pc_a, ~ifen_a};
            1: return {30'd0, iffl_a, iffl_b};
            2: return {30'd0, busy_a, busy_b};
            3: return {16'd0, cnt_a};
            default: return {29'd0, cnt_b};
        endcase
    endfunction

    task automatic drive(input vec_t v);
        Rs_ID = v.rs; Rt_ID = v.rt;
        RsUsed_ID = v.rsu; RtUsed_ID = v.rtu;
        isBranch = v.br; BranchTaken_ID = v.tk;
        MDOp_ID = v.mdop; MFHiLo_ID = v.mfh; MDStart_EX = v.md;
        RegWtaddr_EX = v.wex; RegWrite_EX = v.rwex;
        DMemRead_EX = v.ldex;
        RegWtaddr_MEM = v.wmem; RegWrite_MEM = v.rwmem;
        DMemRead_MEM = v.ldmem;
    endtask

    task automatic want(input string n, input int s,
                        input logic [31:0] e);
        chk_t c;
        c.name = n; c.sel = s; c.exp = e;
        sbq.push_back(c);
    endtask

    task automatic want_stall(input string n, input logic st);
        want(n, 0, {26'd0, {6{st}}});
    endtask

    task automatic check_now();
        chk_t c;
        logic [31:0] a;
        while (sbq.size() > 0) begin
            c = sbq.pop_front();
            a = act(c.sel);
            total++;
            if (a !== c.exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", c.name, a, c.exp);
            end
        end
    endtask

    task automatic check_all();
        @(negedge clk);
        check_now();
    endtask

    task automatic next_cycle(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(idle);
        want_stall("rst_ctl", 1'b1);
        want("rst_sq", 1, 32'd0);
        want("rst_busy", 2, 32'd0);
        want("rst_cnt_a", 3, 32'd0);
        want("rst_cnt_b", 4, 32'd0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t idle, lu, tbl[13];

    initial begin
        idle = mk(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        lu   = mk(8,0,1,0, 0,0,0,0,0, 8,1,1, 0,0,0, 1,0);
        tbl[0]  = lu;
        tbl[1]  = mk(8,0,0,0, 0,0,0,0,0, 8,1,1, 0,0,0, 0,0);
        tbl[2]  = mk(0,0,1,0, 0,0,0,0,0, 0,1,1, 0,0,0, 0,0);
        tbl[3]  = mk(3,9,0,1, 0,0,0,0,0, 9,1,1, 0,0,0, 1,0);
        tbl[4]  = mk(0,9,0,1, 1,0,0,0,0, 9,1,0, 0,0,0, 1,0);
        tbl[5]  = mk(0,9,0,1, 1,0,0,0,0, 0,0,0, 9,1,0, 0,0);
        tbl[6]  = mk(0,9,0,1, 1,0,0,0,0, 0,0,0, 9,1,1, 1,0);
        tbl[7]  = mk(0,9,0,1, 0,0,0,0,0, 0,0,0, 9,1,1, 0,0);
        tbl[8]  = mk(4,5,1,1, 1,1,0,0,0, 6,1,1, 7,1,1, 0,1);
        tbl[9]  = mk(8,0,1,0, 1,1,0,0,0, 8,1,1, 0,0,0, 1,0);
        tbl[10] = mk(4,5,1,1, 0,1,0,0,0, 0,0,0, 0,0,0, 0,0);
        tbl[11] = mk(8,0,1,0, 0,0,0,0,0, 8,0,1, 0,0,0, 0,0);
        tbl[12] = mk(0,0,1,1, 1,1,0,0,0, 0,1,0, 0,1,1, 0,1);

        drive(idle);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            next_cycle(tbl[i]);
            want_stall($sformatf("vec%0d_stall", i), tbl[i].st);
            want($sformatf("vec%0d_sq", i), 1, {31'd0, tbl[i].sq});
            check_all();
        end

        // mul issue at cycle t, mfhi/mult waiting in ID for t+1..t+5
        do_reset();
        for (int k = 0; k < 6; k++) begin
            vec_t v;
            logic b;
            v = idle;
            v.md = (k == 0);
            v.mfh = (k >= 1) && (k != 3);
            v.mdop = (k == 3);
            b = (k >= 1) && (k <= 4);
            next_cycle(v);
            want($sformatf("md%0d_busy", k), 2, {30'd0, b, b});
            want_stall($sformatf("md%0d_stall", k), b);
            check_all();
        end

        // restart while busy reloads the full latency
        for (int k = 0; k < 8; k++) begin
            vec_t v;
            logic b;
            v = idle;
            v.md = (k == 0) || (k == 2);
            b = (k >= 1) && (k <= 6);
            next_cycle(v);
            want($sformatf("mdre%0d_busy", k), 2, {30'd0, b, b});
            check_all();
        end

        do_reset();
        for (int i = 0; i < 10; i++) begin
            next_cycle(lu);
            want($sformatf("cnt%0d_a", i), 3, i);
            want($sformatf("cnt%0d_b", i), 4, (i > 7) ? 7 : i);
            check_all();
        end
        next_cycle(lu);
        want("cnt_a_10", 3, 32'd10);
        want("cnt_b_sat", 4, 32'd7);
        check_all();
        next_cycle(idle);
        want("cnt_a_11", 3, 32'd11);
        want("cnt_b_hold", 4, 32'd7);
        check_all();

        // async reset in the middle of a pending mul
        next_cycle(mk(0,0,0,0, 0,0,0,0,1, 0,0,0, 0,0,0, 0,0));
        next_cycle(lu);
        want("pre_rst_busy", 2, 32'd3);
        check_all();
        #2;
        rst = 1'b1;
        #1;
        want("arst_cnt_a", 3, 32'd0);
        want("arst_cnt_b", 4, 32'd0);
        want("arst_busy", 2, 32'd0);
        want_stall("arst_ctl", 1'b1);
        want("arst_sq", 1, 32'd0);
        check_now();
        next_cycle(tbl[8]);
        want_stall("rst_hold_ctl", 1'b1);
        want("rst_hold_sq", 1, 32'd0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(lu);
        want_stall("post_rst_stall", 1'b1);
        want("post_rst_busy", 2, 32'd0);
        check_all();
        next_cycle(idle);
        want("post_rst_cnt_a", 3, 32'd1);
        want("post_rst_cnt_b", 4, 32'd1);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
